// File: rtl/demux_4x_nbit_reg.sv
// 1-to-4 demultiplexer with one single-entry output register per channel.
// Each channel uses a ready/valid handshake and supports full throughput (drain and refill in one cycle).
module demux_4x_nbit_reg #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] out_a,
    output logic [BUS_WIDTH-1:0] out_b,
    output logic [BUS_WIDTH-1:0] out_c,
    output logic [BUS_WIDTH-1:0] out_d,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready
);

    logic [BUS_WIDTH-1:0] data_q [4];
    logic [3:0]           valid_q;
    logic [3:0]           drain;
    logic [3:0]           load;

    // A channel can accept when it is empty or being drained this cycle.
    always_comb begin
        drain    = valid_q & out_ready;
        in_ready = ~valid_q[in_sel] | out_ready[in_sel];
        load     = '0;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                // Load wins over drain so a simultaneous drain/refill keeps valid high.
                if (load[k]) begin
                    data_q[k]  <= in_data;
                    valid_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign out_a     = data_q[0];
    assign out_b     = data_q[1];
    assign out_c     = data_q[2];
    assign out_d     = data_q[3];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_4x_nbit_reg.sv
// Directed self-checking bench for demux_4x_nbit_reg: reset, routing, backpressure,
// simultaneous drain/fill, channel independence and mid-operation reset.
module tb_demux_4x_nbit_reg;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_a, out_b, out_c, out_d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;

    int total;
    int bad;

    demux_4x_nbit_reg #(.BUS_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Advance past one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        rst_n     = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'b0000;
        #2;
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        total++; if ({out_a, out_b, out_c, out_d} !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=00000000", {out_a, out_b, out_c, out_d}); end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s); #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready); end
        end
        rst_n = 1'b1;
        clk_en = 1'b1;
        #1;
    endtask

    task automatic test_routing();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s); in_data = words[s]; #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_in_ready sel=%0d got=%b exp=1", s, in_ready); end
            step();
            total++; if (out_valid !== (4'b0001 << s)) begin bad++; $display("FAIL route_valid sel=%0d got=%b exp=%b", s, out_valid, 4'b0001 << s); end
            case (s)
                0: begin total++; if (out_a !== 8'h11) begin bad++; $display("FAIL route_a got=%h exp=11", out_a); end end
                1: begin total++; if (out_b !== 8'h22) begin bad++; $display("FAIL route_b got=%h exp=22", out_b); end end
                2: begin total++; if (out_c !== 8'h33) begin bad++; $display("FAIL route_c got=%h exp=33", out_c); end end
                default: begin total++; if (out_d !== 8'h44) begin bad++; $display("FAIL route_d got=%h exp=44", out_d); end end
            endcase
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL route_drained got=%b exp=0000", out_valid); end
        total++; if ({out_a, out_b, out_c, out_d} !== 32'h11223344) begin bad++; $display("FAIL route_hold got=%h exp=11223344", {out_a, out_b, out_c, out_d}); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA5;
        step();
        total++; if (out_b !== 8'hA5 || out_valid[1] !== 1'b1) begin bad++; $display("FAIL bp_load got=%h/%b exp=a5/1", out_b, out_valid[1]); end
        in_data = 8'h5A; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_b got=%b exp=0", in_ready); end
        in_sel = 2'd0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a got=%b exp=1", in_ready); end
        in_sel = 2'd1; #1;
        step();
        total++; if (out_b !== 8'hA5 || out_valid !== 4'b0010) begin bad++; $display("FAIL bp_hold got=%h/%b exp=a5/0010", out_b, out_valid); end
        out_ready = 4'b1111; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        step();
        total++; if (out_b !== 8'h5A || out_valid !== 4'b0010) begin bad++; $display("FAIL bp_accept got=%h/%b exp=5a/0010", out_b, out_valid); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 4'b0000 || out_b !== 8'h5A) begin bad++; $display("FAIL bp_drain got=%h/%b exp=5a/0000", out_b, out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h01;
        step();
        total++; if (out_c !== 8'h01 || out_valid !== 4'b0100) begin bad++; $display("FAIL b2b_fill got=%h/%b exp=01/0100", out_c, out_valid); end
        out_ready = 4'b0100; in_data = 8'h02; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        step();
        total++; if (out_c !== 8'h02 || out_valid !== 4'b0100) begin bad++; $display("FAIL b2b_first got=%h/%b exp=02/0100", out_c, out_valid); end
        in_data = 8'h03;
        step();
        total++; if (out_c !== 8'h03 || out_valid !== 4'b0100) begin bad++; $display("FAIL b2b_second got=%h/%b exp=03/0100", out_c, out_valid); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 4'b0000 || out_c !== 8'h03) begin bad++; $display("FAIL b2b_drain got=%h/%b exp=03/0000", out_c, out_valid); end
    endtask

    task automatic test_independence();
        do_reset();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hAA;
        step();
        in_sel = 2'd3; in_data = 8'hDD;
        step();
        in_sel = 2'd1; in_data = 8'h77;
        step();
        in_valid = 1'b0; #1;
        total++; if (out_b !== 8'h77) begin bad++; $display("FAIL ind_b got=%h exp=77", out_b); end
        total++; if (out_a !== 8'hAA || out_d !== 8'hDD) begin bad++; $display("FAIL ind_ad got=%h/%h exp=aa/dd", out_a, out_d); end
        total++; if (out_valid !== 4'b1011) begin bad++; $display("FAIL ind_valid got=%b exp=1011", out_valid); end
        // Drain only d; a and b must stay put.
        out_ready = 4'b1000;
        step();
        total++; if (out_valid !== 4'b0011 || out_a !== 8'hAA) begin bad++; $display("FAIL ind_partial got=%h/%b exp=aa/0011", out_a, out_valid); end
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hEE; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ind_refuse_ready got=%b exp=0", in_ready); end
        step();
        total++; if (out_a !== 8'hAA) begin bad++; $display("FAIL ind_refused got=%h exp=aa", out_a); end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s); in_data = 8'hC0 + 8'(s);
            step();
        end
        in_valid = 1'b0; #1;
        total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL mid_full got=%b exp=1111", out_valid); end
        out_ready = 4'b1111;
        rst_n = 1'b0; #1;
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL mid_valid got=%b exp=0000", out_valid); end
        total++; if ({out_a, out_b, out_c, out_d} !== 32'h0) begin bad++; $display("FAIL mid_data got=%h exp=00000000", {out_a, out_b, out_c, out_d}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
        step();
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL mid_after got=%b exp=0000", out_valid); end
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h9C;
        step();
        in_valid = 1'b0;
        total++; if (out_d !== 8'h9C || out_valid !== 4'b1000) begin bad++; $display("FAIL mid_first_accept got=%h/%b exp=9c/1000", out_d, out_valid); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        clk_en = 1'b0;
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_independence();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_4x_nbit_reg.md
DEMUX_4X_NBIT_REG -- requirements
Module: demux_4x_nbit_reg

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, data width of the input and each output channel.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_data  input  BUS_WIDTH  word to route.
REQ-005 SHALL have port in_sel  input  2  destination channel: 0=a, 1=b, 2=c, 3=d.
REQ-006 SHALL have port in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have ports out_a, out_b, out_c, out_d  output  BUS_WIDTH each  registered channel data.
REQ-009 SHALL have port out_valid  output  4  per-channel valid; bit 0=a ... bit 3=d.
REQ-010 SHALL have port out_ready  input  4  per-channel downstream ready; same bit order.

Function
REQ-011 SHALL hold one single-entry register per channel; out_valid[k] marks that register as full.
REQ-012 SHALL drive in_ready combinationally as ~out_valid[in_sel] | out_ready[in_sel]; in_ready SHALL NOT depend on in_valid.
REQ-013 SHALL accept a word when in_valid & in_ready at a rising clk edge: the channel selected by in_sel loads in_data and sets its out_valid bit at that edge (latency 1 cycle).
REQ-014 SHALL drain channel k when out_valid[k] & out_ready[k]; out_valid[k] clears at that edge unless REQ-015 applies.
REQ-015 On simultaneous drain and accept to the same channel, out_valid[k] SHALL stay 1 and out_k SHALL take the new word (full throughput, one word per cycle per channel).
REQ-016 SHALL load at most one channel per cycle; unselected channels keep their data and valid bits, and their drains proceed independently in the same cycle.
REQ-017 While out_valid[k] & ~out_ready[k], out_k SHALL stay stable and out_valid[k] SHALL stay asserted.
REQ-018 When in_valid is 0, or in_ready is 0, no channel register or valid bit SHALL change except through drains.
REQ-019 When out_valid[k] is 0, out_k SHALL hold its last loaded value (0 after reset).
REQ-020 A word refused (in_valid=1, in_ready=0) SHALL NOT be stored; the upstream holds it until accepted.
REQ-021 out_ready[k] asserted while out_valid[k]=0 SHALL have no effect.

Reset
REQ-022 When rst_n=0, out_valid SHALL clear to 4'b0000 and out_a..out_d to 0 immediately, without waiting for clk.
REQ-023 During and directly after reset, in_ready SHALL be 1 for every in_sel value.
REQ-024 Reset asserted mid-operation SHALL discard all buffered words; none SHALL appear on outputs after rst_n returns to 1.
REQ-025 The first accept SHALL occur at the first rising clk edge with rst_n=1 and in_valid=1.

Verification
REQ-026 Reset: rst_n=0 with clk stopped -> out_valid=0000, out_a..d=0, in_ready=1.
REQ-027 Routing: out_ready=1111; send 8'h11,22,33,44 with in_sel 0,1,2,3 on consecutive cycles -> each appears one cycle later on out_a,b,c,d with the matching out_valid bit pulsing for one cycle.
REQ-028 Backpressure: out_ready[1]=0; send 8'hA5 to b, then 8'h5A to b -> out_b=A5 held, in_ready=0 for in_sel=1 and 1 for in_sel=0; raise out_ready[1] -> 8'h5A accepted at that edge, out_b=5A next cycle.
REQ-029 Simultaneous drain/fill: channel c full with 8'h01, out_ready[2]=1, send 8'h02 to c each cycle -> out_valid[2] stays 1, out_c 01 then 02, no bubble.
REQ-030 Independence: a and d full with out_ready=0000; send 8'h77 to b -> out_b=77, out_a and out_d unchanged.
REQ-031 Mid-operation reset: all four channels full, pulse rst_n=0 between clk edges -> out_valid=0000 at once, nothing emitted after release.
